// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data widths, register-field positions and the
// IF/ID register layout used by the fetch stage and its neighbours.
package pipe_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    // sll $0,$0,0 -- architecturally a no-op, used as the pipeline bubble
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // MIPS rs/rt field positions inside an instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Contents of an empty IF/ID slot
    function automatic if_id_t make_bubble(input logic [INSTR_W-1:0] nop);
        if_id_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled events until the all-ones ceiling is reached
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values
        if (!reset_n || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register, steered by
// the load-use stall unit (PCWrite / IF_ID_Write) and by EX-stage redirects.
// Also keeps debug counters for stalls and flushes plus a sticky flag for
// inconsistent stall-unit enables.
module fetch_if_id_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [4:0]         if_id_rs,
    output logic [4:0]         if_id_rt,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count,
    output logic               protocol_err
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_pc;
    if_id_t            if_id;
    logic              stall_cycle;
    logic              enable_mismatch;
    logic [1:0]        unused_target_lsbs;

    // Redirect targets are word aligned; the low two bits carry no meaning
    assign redirect_pc        = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsbs = branch_target[1:0];

    // Wraps naturally modulo 2^32
    assign pc_plus4 = pc + 32'd4;

    // A redirect outranks the stall enables, so it is neither a stall nor a protocol violation
    assign stall_cycle     = !branch_taken && !PCWrite && !IF_ID_Write;
    assign enable_mismatch = !branch_taken && (PCWrite != IF_ID_Write);

    // PC, IF/ID and sticky error register with reset > redirect > enables priority
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc           <= RESET_PC;
            if_id        <= make_bubble(NOP_INSTR);
            protocol_err <= 1'b0;
        end else if (branch_taken) begin
            pc    <= redirect_pc;
            if_id <= make_bubble(NOP_INSTR);
        end else begin
            // NOTE: a register not assigned on some path simply holds; in always_ff that is a clock enable, not a latch
            if (PCWrite) begin
                pc <= pc_plus4;
            end
            if (IF_ID_Write) begin
                if_id.pc    <= pc;
                if_id.pc4   <= pc_plus4;
                if_id.instr <= imem_rdata;
                if_id.valid <= 1'b1;
            end
            if (enable_mismatch) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_instr = if_id.instr;
    assign if_id_valid = if_id.valid;
    assign if_id_rs    = if_id.instr[RS_MSB:RS_LSB];
    assign if_id_rt    = if_id.instr[RT_MSB:RT_LSB];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (stall_cycle),
        .count   (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (branch_taken),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for fetch_if_id_stage. Two instances share all inputs: one with
// the default 16-bit counters and one with 4-bit counters for saturation.
module tb_fetch_if_id_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] a_imem_addr, a_imem_rdata, a_pc, a_pc4, a_instr;
    logic        a_valid, a_perr;
    logic [4:0]  a_rs, a_rt;
    logic [15:0] a_stall, a_flush;

    logic [31:0] b_imem_addr, b_imem_rdata, b_pc, b_pc4, b_instr;
    logic        b_valid, b_perr;
    logic [4:0]  b_rs, b_rt;
    logic [3:0]  b_stall, b_flush;

    // Instruction ROM model: addr | 0xA000_0000 unless a specific word is forced
    logic        ovr_en;
    logic [31:0] ovr_word;
    assign a_imem_rdata = ovr_en ? ovr_word : (a_imem_addr | 32'hA000_0000);
    assign b_imem_rdata = ovr_en ? ovr_word : (b_imem_addr | 32'hA000_0000);

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_if_id_stage dut_a (
        .clk(clk), .reset_n(reset_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
        .if_id_pc(a_pc), .if_id_pc4(a_pc4), .if_id_instr(a_instr), .if_id_valid(a_valid),
        .if_id_rs(a_rs), .if_id_rt(a_rt),
        .stall_count(a_stall), .flush_count(a_flush), .protocol_err(a_perr)
    );

    fetch_if_id_stage #(.CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .if_id_pc(b_pc), .if_id_pc4(b_pc4), .if_id_instr(b_instr), .if_id_valid(b_valid),
        .if_id_rs(b_rs), .if_id_rt(b_rt),
        .stall_count(b_stall), .flush_count(b_flush), .protocol_err(b_perr)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " a.imem_addr"}, a_imem_addr, 32'h0);
        check({tag, " a.if_id_pc"},  a_pc,        32'h0);
        check({tag, " a.if_id_pc4"}, a_pc4,       32'h0);
        check({tag, " a.instr"},     a_instr,     32'h0);
        check({tag, " a.valid"},     {31'b0, a_valid}, 32'h0);
        check({tag, " a.stall"},     {16'b0, a_stall}, 32'h0);
        check({tag, " a.flush"},     {16'b0, a_flush}, 32'h0);
        check({tag, " a.perr"},      {31'b0, a_perr},  32'h0);
        check({tag, " b.imem_addr"}, b_imem_addr, 32'h0);
        check({tag, " b.valid"},     {31'b0, b_valid}, 32'h0);
        check({tag, " b.stall"},     {28'b0, b_stall}, 32'h0);
        check({tag, " b.perr"},      {31'b0, b_perr},  32'h0);
    endtask

    initial begin
        reset_n       = 1'b0;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        ovr_en        = 1'b0;
        ovr_word      = 32'h0;

        // Reset
        step(2);
        check_reset_state("reset");

        // 1: release and stream
        reset_n = 1'b1;
        step();
        check("t1 imem_addr c1", a_imem_addr, 32'h4);
        check("t1 if_id_pc c1",  a_pc,        32'h0);
        check("t1 if_id_pc4 c1", a_pc4,       32'h4);
        check("t1 instr c1",     a_instr,     32'hA000_0000);
        check("t1 valid c1",     {31'b0, a_valid}, 32'h1);
        step(3);
        check("t1 imem_addr c4", a_imem_addr, 32'h10);
        check("t1 if_id_pc c4",  a_pc,        32'hC);
        check("t1 instr c4",     a_instr,     32'hA000_000C);

        // 2: full stall for 3 cycles
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        step(3);
        check("t2 imem_addr",  a_imem_addr, 32'h10);
        check("t2 if_id_pc",   a_pc,        32'hC);
        check("t2 instr",      a_instr,     32'hA000_000C);
        check("t2 stall_count", {16'b0, a_stall}, 32'd3);
        check("t2 perr",       {31'b0, a_perr},  32'h0);

        // 3: redirect during a stall
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        check("t3 imem_addr",  a_imem_addr, 32'h100);
        check("t3 valid",      {31'b0, a_valid}, 32'h0);
        check("t3 instr",      a_instr,     32'h0);
        check("t3 if_id_pc",   a_pc,        32'h0);
        check("t3 flush_count", {16'b0, a_flush}, 32'd1);
        check("t3 stall_count", {16'b0, a_stall}, 32'd3);
        check("t3 perr",       {31'b0, a_perr},  32'h0);

        // First fetch from the target, with rs=1 rt=2 (lw $2,4($1))
        branch_taken = 1'b0;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ovr_en       = 1'b1;
        ovr_word     = 32'h8C22_0004;
        step();
        check("t3 refetch pc",  a_pc,        32'h100);
        check("t3 refetch pc4", a_pc4,       32'h104);
        check("t3 refetch valid", {31'b0, a_valid}, 32'h1);
        check("t3 rs",          {27'b0, a_rs}, 32'd1);
        check("t3 rt",          {27'b0, a_rt}, 32'd2);
        check("t3 imem_addr",   a_imem_addr, 32'h104);
        ovr_en = 1'b0;

        // 4: wrap past 0xFFFF_FFFC
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        check("t4 imem_addr top", a_imem_addr, 32'hFFFF_FFFC);
        check("t4 flush_count",   {16'b0, a_flush}, 32'd2);
        branch_taken = 1'b0;
        step();
        check("t4 imem_addr wrap", a_imem_addr, 32'h0);
        check("t4 if_id_pc",       a_pc,        32'hFFFF_FFFC);
        check("t4 if_id_pc4",      a_pc4,       32'h0);
        check("t4 instr",          a_instr,     32'hFFFF_FFFC);

        // 5: PCWrite without IF_ID_Write
        IF_ID_Write = 1'b0;
        step();
        check("t5 imem_addr",  a_imem_addr, 32'h4);
        check("t5 if_id_pc",   a_pc,        32'hFFFF_FFFC);
        check("t5 perr",       {31'b0, a_perr}, 32'h1);
        check("t5 stall_count", {16'b0, a_stall}, 32'd3);
        IF_ID_Write = 1'b1;
        step();
        check("t5 perr sticky", {31'b0, a_perr}, 32'h1);
        check("t5 if_id_pc",    a_pc,        32'h4);
        check("t5 imem_addr",   a_imem_addr, 32'h8);

        // 6: long stall, saturation on the 4-bit instance
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        step(11);
        check("t6 b.stall 14", {28'b0, b_stall}, 32'd14);
        step();
        check("t6 b.stall 15", {28'b0, b_stall}, 32'd15);
        step(8);
        check("t6 b.stall sat", {28'b0, b_stall}, 32'd15);
        check("t6 a.stall",     {16'b0, a_stall}, 32'd23);
        check("t6 b.flush",     {28'b0, b_flush}, 32'd2);

        // Reset while still stalling
        reset_n = 1'b0;
        step();
        check_reset_state("t6 reset");

        reset_n     = 1'b1;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        step();
        check("t6 post valid",     {31'b0, a_valid}, 32'h1);
        check("t6 post if_id_pc",  a_pc,        32'h0);
        check("t6 post imem_addr", a_imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
